// File: rtl/mem_byte_bridge.sv
// Word-to-byte bus bridge: splits each 32-bit CPU request into four big-endian
// byte beats on the memory side, or faults misaligned/out-of-range addresses.
module mem_byte_bridge #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        rw_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        fault_o,
  output logic        b_en_o,
  output logic        b_rw_o,
  output logic [31:0] b_addr_o,
  output logic [7:0]  b_wdata_o,
  input  logic [7:0]  b_rdata_i
);

  localparam int unsigned LAST_WORD = MEM_BYTES - 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q;
  logic [1:0]  beat_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        fault_q;
  logic        b_en_q;
  logic        b_rw_q;
  logic [31:0] b_addr_q;
  logic [7:0]  b_wdata_q;

  logic        addr_ok_c;
  logic [1:0]  beat_nx_c;
  logic [31:0] b_addr_d;
  logic [7:0]  b_wdata_d;
  logic [31:0] rdata_d;

  // Address check, next-beat address/data and read-lane merge.
  always_comb begin
    addr_ok_c = (addr_i[1:0] == 2'b00) && (addr_i <= 32'(LAST_WORD));
    beat_nx_c = beat_q + 2'd1;
    b_addr_d  = addr_q + 32'(beat_nx_c);
    rdata_d   = rdata_q;
    case (beat_nx_c)
      2'd1:    b_wdata_d = wdata_q[23:16];
      2'd2:    b_wdata_d = wdata_q[15:8];
      2'd3:    b_wdata_d = wdata_q[7:0];
      default: b_wdata_d = wdata_q[31:24];
    endcase
    case (beat_q)
      2'd0:    rdata_d[31:24] = b_rdata_i;
      2'd1:    rdata_d[23:16] = b_rdata_i;
      2'd2:    rdata_d[15:8]  = b_rdata_i;
      default: rdata_d[7:0]   = b_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      rw_q      <= 1'b1;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      b_en_q    <= 1'b0;
      b_rw_q    <= 1'b1;
      b_addr_q  <= 32'd0;
      b_wdata_q <= 8'd0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_i) begin
            rw_q    <= rw_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (addr_ok_c) begin
              state_q   <= S_BUSY;
              beat_q    <= 2'd0;
              b_en_q    <= 1'b1;
              b_rw_q    <= rw_i;
              b_addr_q  <= addr_i;
              b_wdata_q <= wdata_i[31:24];
            end else begin
              // Rejected: report immediately, memory side untouched.
              state_q <= S_DONE;
              ready_q <= 1'b1;
              fault_q <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (rw_q) rdata_q <= rdata_d;
          if (beat_q != 2'd3) begin
            beat_q    <= beat_nx_c;
            b_addr_q  <= b_addr_d;
            b_wdata_q <= b_wdata_d;
          end else begin
            state_q <= S_DONE;
            b_en_q  <= 1'b0;
            b_rw_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata_o   = rdata_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;
  assign b_en_o    = b_en_q;
  assign b_rw_o    = b_rw_q;
  assign b_addr_o  = b_addr_q;
  assign b_wdata_o = b_wdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Bench for mem_byte_bridge: byte memory model plus a word-level reference of
// memory contents and last read value, driven by directed and random requests.
module tb_mem_byte_bridge;

  localparam int unsigned MEM_BYTES = 128;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rw_in;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;
  logic        b_en;
  logic        b_rw;
  logic [31:0] b_addr;
  logic [7:0]  b_wdata;
  logic [7:0]  b_rdata;

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] ref_rdata;
  logic        fill;
  logic [31:0] q_addr [$];
  logic        q_rw [$];
  logic [7:0]  q_wd [$];
  int          cyc;
  int          checks;
  int          errors;

  mem_byte_bridge #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .rw_i(rw_in), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready), .fault_o(fault),
    .b_en_o(b_en), .b_rw_o(b_rw), .b_addr_o(b_addr), .b_wdata_o(b_wdata),
    .b_rdata_i(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: combinational read, write on the edge closing a write beat.
  assign b_rdata = mem[b_addr[6:0]];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'(i * 29 + 7);
    end else if (b_en && !b_rw) begin
      mem[b_addr[6:0]] <= b_wdata;
    end
  end

  // Beat monitor: what the memory saw on each edge.
  always @(posedge clk) begin
    if (b_en) begin
      q_addr.push_back(b_addr);
      q_rw.push_back(b_rw);
      q_wd.push_back(b_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request with en dropped right after acceptance; checks latency,
  // status, beat sequence, memory effect and rdata against the reference.
  task automatic do_txn(input logic r, input logic [31:0] a, input logic [31:0] wd);
    int base;
    int lat;
    bit legal;
    logic [31:0] exp_wd;
    legal = (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
    base  = q_addr.size();
    @(negedge clk);
    en = 1'b1; rw_in = r; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0; rw_in = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (ready !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), legal ? 32'd4 : 32'd0);
    chk("fault", 32'(fault), legal ? 32'd0 : 32'd1);
    if (legal && r) ref_rdata = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    if (legal && !r) begin
      for (int k = 0; k < 4; k++) ref_mem[a+k] = 8'(wd >> (8 * (3 - k)));
    end
    chk("rdata", rdata, ref_rdata);
    chk("nbeats", 32'(q_addr.size() - base), legal ? 32'd4 : 32'd0);
    if (legal && q_addr.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("beat_addr", q_addr[base+k], a + 32'(k));
        chk("beat_rw", 32'(q_rw[base+k]), 32'(r));
        if (!r) begin
          exp_wd = wd >> (8 * (3 - k));
          chk("beat_wdata", 32'(q_wd[base+k]), 32'(exp_wd[7:0]));
          chk("mem_byte", 32'(mem[a[6:0] + 7'(k)]), 32'(ref_mem[a+k]));
        end
      end
    end
    @(negedge clk);
    chk("ready_pulse", 32'(ready), 32'd0);
    chk("fault_clear", 32'(fault), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int t1;
    int lat;
    checks = 0; errors = 0; cyc = 0;
    en = 1'b0; rw_in = 1'b1; addr = 32'd0; wdata = 32'd0;
    rst_n = 1'b0; fill = 1'b1;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'(i * 29 + 7);
    ref_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fill = 1'b0;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_b_en", 32'(b_en), 32'd0);
    chk("rst_b_rw", 32'(b_rw), 32'd1);
    chk("rst_b_addr", b_addr, 32'd0);
    chk("rst_b_wdata", 32'(b_wdata), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd0);
    chk("idle_b_en", 32'(b_en), 32'd0);

    // Preload 00,1F,00,18 at 0x00 and read it back.
    do_txn(1'b0, 32'h00, 32'h001F0018);
    do_txn(1'b1, 32'h00, 32'h0);
    chk("read0_value", rdata, 32'h001F0018);
    // Write then read 0x20; misaligned and out-of-range faults keep rdata.
    do_txn(1'b0, 32'h20, 32'hDEADBEEF);
    chk("write_keeps_rdata", rdata, 32'h001F0018);
    do_txn(1'b1, 32'h20, 32'h0);
    chk("read20_value", rdata, 32'hDEADBEEF);
    do_txn(1'b1, 32'h0E, 32'h0);
    do_txn(1'b1, 32'h7C, 32'h0);
    do_txn(1'b1, 32'h80, 32'h0);
    do_txn(1'b0, 32'hFFFF_FFFC, 32'h12345678);

    // Reset during beat 2 of a write to 0x10.
    @(negedge clk);
    en = 1'b1; rw_in = 1'b0; addr = 32'h10; wdata = 32'hA5C35A3C;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_b_en", 32'(b_en), 32'd0);
    chk("abort_b_rw", 32'(b_rw), 32'd1);
    chk("abort_b_addr", b_addr, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    ref_mem[16] = 8'hA5; ref_mem[17] = 8'hC3; ref_rdata = 32'd0;
    for (int k = 16; k < 20; k++) chk("abort_mem", 32'(mem[k]), 32'(ref_mem[k]));
    rst_n = 1'b1;
    do_txn(1'b1, 32'h00, 32'h0);

    // Back-to-back reads with en held high, address switched on ready.
    @(negedge clk);
    en = 1'b1; rw_in = 1'b1; addr = 32'h00;
    @(posedge clk);
    @(negedge clk);
    t1 = cyc;
    lat = 0;
    while (ready !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    chk("b2b_ready1", 32'(ready), 32'd1);
    chk("b2b_rdata1", rdata, {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]});
    addr = 32'h04;
    lat = 0;
    while (b_en !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    chk("b2b_period", 32'(cyc - t1), 32'd6);
    lat = 0;
    while (ready !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
    en = 1'b0;
    chk("b2b_ready2", 32'(ready), 32'd1);
    ref_rdata = {ref_mem[4], ref_mem[5], ref_mem[6], ref_mem[7]};
    chk("b2b_rdata2", rdata, ref_rdata);
    @(negedge clk);

    // Random mix of legal, misaligned and out-of-range requests.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 127)) | 32'd1;
        1:       a = 32'd128 + 32'(4 * $urandom_range(0, 63));
        2:       a = 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
        default: a = 32'(4 * $urandom_range(0, 31));
      endcase
      do_txn(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
